uart_rx_core: RTL and testbench

UART_RX_CORE -- requirements
Module: uart_rx_core

---
 rtl/uart_rx_core.sv | 193 +++++++++++++++++++
 tb/tb_uart_rx_core.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver with ready/valid holding register and error pulses.
// Optional parity checking is compiled in when UART_RX_PARITY_EN is defined.
module uart_rx_core #(
  parameter int BAUD_DIV   = 434,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] dout,
  output logic                 dout_val,
  input  logic                 dout_rdy,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  if (BAUD_DIV < 8 || BAUD_DIV > 65535) begin : g_bad_baud
    $error("uart_rx_core: BAUD_DIV out of range");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data
    $error("uart_rx_core: DATA_BITS out of range");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_rx_core: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_par
    $error("uart_rx_core: PARITY_ODD must be 0 or 1");
  end

  localparam logic [15:0] BIT_END  = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_END = 16'(BAUD_DIV / 2 - 1);
  localparam logic [3:0]  DATA_END = 4'(DATA_BITS - 1);
  localparam logic        STOP_END = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t state, state_nxt;

  logic                 sync1;
  logic                 rxs;
  logic                 sync_live;
  logic                 armed;
  logic [15:0]          timer;
  logic [3:0]           bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] payload;
  logic                 done;
  logic                 ferr_acc;
  logic                 tick;
  logic                 fall;

  // The edge is taken from the synchroniser pair itself so START begins on the
  // same clock that rxs goes low; armed blocks edges until a real high is seen.
  assign fall = armed & rxs & ~sync1;
  assign tick = (state == START) ? (timer == HALF_END) : (timer == BIT_END);
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (fall) state_nxt = START;
      START: if (tick) state_nxt = rxs ? IDLE : DATA;
      DATA: begin
        if (tick && bit_cnt == DATA_END) begin
`ifdef UART_RX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick) state_nxt = STOP;
`endif
      STOP:  if (tick && stop_cnt == STOP_END) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  logic perr_acc;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b1;
      rxs       <= 1'b1;
      sync_live <= 1'b0;
      armed     <= 1'b0;
      timer     <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      payload   <= '0;
      done      <= 1'b0;
      ferr_acc  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_acc  <= 1'b0;
`endif
    end else begin
      sync1     <= rxd;
      rxs       <= sync1;
      sync_live <= 1'b1;
      armed     <= armed | (sync_live & sync1);
      done      <= 1'b0;
      if (state == IDLE || tick) timer <= '0;
      else                       timer <= timer + 16'd1;
      case (state)
        START: begin
          if (tick) begin
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            ferr_acc <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_acc <= 1'b0;
`endif
          end
        end
        DATA: begin
          if (tick) begin
            payload <= {rxs, payload[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) perr_acc <= rxs ^ (^payload) ^ (PARITY_ODD != 0);
        end
`endif
        STOP: begin
          if (tick) begin
            if (!rxs) ferr_acc <= 1'b1;
            stop_cnt <= stop_cnt + 1'b1;
            if (stop_cnt == STOP_END) done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Completion cycle: exactly one outcome, frame error first, then parity, then
  // delivery into the holding register or an overrun if it cannot be freed.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_val   <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (dout_val && dout_rdy) dout_val <= 1'b0;
      if (done) begin
        if (ferr_acc) frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
        else if (perr_acc) parity_err <= 1'b1;
`endif
        else if (!dout_val || dout_rdy) begin
          dout     <= payload;
          dout_val <= 1'b1;
        end else overrun <= 1'b1;
      end
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core at BAUD_DIV=16, 8N1 (8E1 with UART_RX_PARITY_EN).
// Delivered bytes are checked against a scoreboard queue; error pulses are counted.
module tb_uart_rx_core;

  localparam int BD = 16;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int LAT = BD / 2 + (8 + P + 1) * BD + 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       dout_rdy = 1'b1;
  logic [7:0] dout;
  logic       dout_val;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;
  logic       busy;

  uart_rx_core #(
    .BAUD_DIV  (BD),
    .DATA_BITS (8),
    .STOP_BITS (1),
    .PARITY_ODD(0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .dout      (dout),
    .dout_val  (dout_val),
    .dout_rdy  (dout_rdy),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  int ovr_cnt = 0;
  int rise_cnt = 0;
  int hs_cnt = 0;
  int busy_cnt = 0;
  logic prev_val = 1'b0;
  logic [7:0] exp_q[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor samples on the falling edge, well away from the DUT's active edge.
  always @(negedge clk) begin
    if (frame_err)  ferr_cnt++;
    if (parity_err) perr_cnt++;
    if (overrun)    ovr_cnt++;
    if (busy)       busy_cnt++;
    if (dout_val && !prev_val) rise_cnt++;
    prev_val = dout_val;
    if (!rst && dout_val && dout_rdy) begin
      hs_cnt++;
      if (exp_q.size() == 0) checkOutput("sb_underflow", 32'(exp_q.size()), 32'd1);
      else                   checkOutput("sb_data", {24'd0, dout}, {24'd0, exp_q.pop_front()});
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) step();
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic stop_b, input logic par_b);
    rxd = 1'b0;
    repeat (BD) step();
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (BD) step();
    end
`ifdef UART_RX_PARITY_EN
    rxd = par_b;
    repeat (BD) step();
`else
    if (par_b === 1'bx) rxd = 1'b1;
`endif
    rxd = stop_b;
    repeat (BD) step();
    rxd = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_b;
    logic [7:0] exp_dout;
    int         exp_ferr;
    int         exp_dlv;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int b_f, b_r, b_o, b_h, b_p, b_b, lat;
    vecs[0] = '{8'h00, 1'b1, 8'h00, 0, 1};
    vecs[1] = '{8'hFF, 1'b1, 8'hFF, 0, 1};
    vecs[2] = '{8'h3C, 1'b0, 8'hFF, 1, 0};
    vecs[3] = '{8'h5A, 1'b1, 8'h5A, 0, 1};
    vecs[4] = '{8'h81, 1'b1, 8'h81, 0, 1};
    vecs[5] = '{8'hC3, 1'b0, 8'h81, 1, 0};
    vecs[6] = '{8'h3C, 1'b1, 8'h3C, 0, 1};

    rst = 1'b1;
    repeat (3) step();
    checkOutput("rst_dout", {24'd0, dout}, 32'd0);
    checkOutput("rst_val", {31'd0, dout_val}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_flags", {29'd0, frame_err, parity_err, overrun}, 32'd0);
    rst = 1'b0;
    idle(10);

    // Single frame with latency measured from the rxd falling edge.
    b_f = ferr_cnt; b_o = ovr_cnt; b_p = perr_cnt;
    exp_q.push_back(8'hA5);
    lat = -1;
    fork
      applyStimulus(8'hA5, 1'b1, ^8'hA5);
      begin
        for (int k = 1; k <= 400 && lat < 0; k++) begin
          step();
          if (dout_val) lat = k;
        end
        checkOutput("latency", 32'(lat), 32'(LAT));
        step();
        checkOutput("val_one_cycle", {31'd0, dout_val}, 32'd0);
      end
    join
    idle(20);
    checkOutput("a5_dout", {24'd0, dout}, 32'hA5);
    checkOutput("a5_flags", 32'(ferr_cnt - b_f + ovr_cnt - b_o + perr_cnt - b_p), 32'd0);

    for (int i = 0; i < 7; i++) begin
      b_f = ferr_cnt; b_r = rise_cnt;
      if (vecs[i].stop_b) exp_q.push_back(vecs[i].data);
      applyStimulus(vecs[i].data, vecs[i].stop_b, ^vecs[i].data);
      idle(20);
      checkOutput($sformatf("vec%0d_ferr", i), 32'(ferr_cnt - b_f), 32'(vecs[i].exp_ferr));
      checkOutput($sformatf("vec%0d_dlv", i), 32'(rise_cnt - b_r), 32'(vecs[i].exp_dlv));
      checkOutput($sformatf("vec%0d_dout", i), {24'd0, dout}, {24'd0, vecs[i].exp_dout});
    end

    // Short low glitch must be rejected at the start-bit centre.
    b_f = ferr_cnt; b_r = rise_cnt; b_o = ovr_cnt; b_p = perr_cnt;
    rxd = 1'b0;
    repeat (4) step();
    checkOutput("glitch_busy", {31'd0, busy}, 32'd1);
    idle(20);
    checkOutput("glitch_idle", {31'd0, busy}, 32'd0);
    checkOutput("glitch_dlv", 32'(rise_cnt - b_r), 32'd0);
    checkOutput("glitch_flags", 32'(ferr_cnt - b_f + ovr_cnt - b_o + perr_cnt - b_p), 32'd0);

    // Overrun: consumer stalled, second good frame is dropped.
    dout_rdy = 1'b0;
    b_o = ovr_cnt; b_h = hs_cnt;
    exp_q.push_back(8'h11);
    applyStimulus(8'h11, 1'b1, ^8'h11);
    idle(20);
    checkOutput("ovr_first_val", {31'd0, dout_val}, 32'd1);
    checkOutput("ovr_first_dout", {24'd0, dout}, 32'h11);
    applyStimulus(8'h22, 1'b1, ^8'h22);
    idle(20);
    checkOutput("ovr_pulse", 32'(ovr_cnt - b_o), 32'd1);
    checkOutput("ovr_dout_kept", {24'd0, dout}, 32'h11);
    dout_rdy = 1'b1;
    repeat (3) step();
    checkOutput("ovr_accept_once", 32'(hs_cnt - b_h), 32'd1);
    checkOutput("ovr_val_clear", {31'd0, dout_val}, 32'd0);

`ifdef UART_RX_PARITY_EN
    b_p = perr_cnt; b_r = rise_cnt;
    applyStimulus(8'h07, 1'b1, 1'b0);
    idle(20);
    checkOutput("par_bad_pulse", 32'(perr_cnt - b_p), 32'd1);
    checkOutput("par_bad_dlv", 32'(rise_cnt - b_r), 32'd0);
    b_p = perr_cnt;
    exp_q.push_back(8'h07);
    applyStimulus(8'h07, 1'b1, 1'b1);
    idle(20);
    checkOutput("par_good_dout", {24'd0, dout}, 32'h07);
    checkOutput("par_good_pulse", 32'(perr_cnt - b_p), 32'd0);
`endif

    // Reset in the middle of data bit 4 with the line held low.
    b_f = ferr_cnt;
    rxd = 1'b0;
    repeat (BD / 2 + 5 * BD) step();
    checkOutput("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    step();
    checkOutput("mid_rst_dout", {24'd0, dout}, 32'd0);
    checkOutput("mid_rst_val", {31'd0, dout_val}, 32'd0);
    checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    b_b = busy_cnt; b_r = rise_cnt;
    repeat (40) step();
    checkOutput("low_no_start", 32'(busy_cnt - b_b), 32'd0);
    checkOutput("low_no_dlv", 32'(rise_cnt - b_r), 32'd0);
    checkOutput("mid_no_flags", 32'(ferr_cnt - b_f), 32'd0);
    idle(20);
    exp_q.push_back(8'h96);
    applyStimulus(8'h96, 1'b1, ^8'h96);
    idle(20);
    checkOutput("post_rst_dout", {24'd0, dout}, 32'h96);
    checkOutput("post_rst_dlv", 32'(rise_cnt - b_r), 32'd1);

    checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
